// File: rtl/pc_stack_unit.sv
// Program-sequencing unit: one-hot instruction-phase generator, program counter and hardware
// call/return stack. Define PC_STACK_WRAP_EN for a circular stack that overwrites on overflow.
module pc_stack_unit #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 8,
  parameter int PHASES      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [2:0]                       cmd,
  input  logic [PC_W-1:0]                  target,
  input  logic                             clear_err,
  output logic [PC_W-1:0]                  pc,
  output logic [PHASES-1:0]                phase_en,
  output logic                             cycle_end,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(STACK_DEPTH - 1);

  typedef enum logic [2:0] {
    CMD_INC    = 3'd0,
    CMD_JUMP   = 3'd1,
    CMD_CALL   = 3'd2,
    CMD_RETURN = 3'd3,
    CMD_SKIP   = 3'd4
  } cmd_e;

  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PC_W-1:0]  top;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  pc_plus2;
  logic [PC_W-1:0]  pc_next;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;

  // wr_ptr always names the slot the next push writes; the top of stack sits just below it.
  assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
  assign rd_ptr     = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
  assign top        = stack_mem[rd_ptr];

  assign pc_plus1    = pc + PC_W'(1);
  assign pc_plus2    = pc + PC_W'(2);
  assign cycle_end   = phase_en[PHASES-1] & ~stall;
  assign stack_full  = (depth == DEPTH_MAX);
  assign stack_empty = (depth == '0);

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (cycle_end) begin
      case (cmd)
        CMD_JUMP: pc_next = target;
        CMD_CALL: begin
          pc_next = target;
`ifdef PC_STACK_WRAP_EN
          push = 1'b1;
`else
          if (stack_full) ovf_set = 1'b1;
          else            push    = 1'b1;
`endif
        end
        CMD_RETURN: begin
          if (stack_empty) begin
            pc_next = pc_plus1;
            unf_set = 1'b1;
          end else begin
            pc_next = top;
            pop     = 1'b1;
          end
        end
        CMD_SKIP: pc_next = pc_plus2;
        default:  pc_next = pc_plus1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      phase_en  <= PHASES'(1);
      depth     <= '0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!stall) phase_en <= {phase_en[PHASES-2:0], phase_en[PHASES-1]};
      pc <= pc_next;
      if (push) begin
        wr_ptr <= wr_ptr_inc;
        if (!stack_full) depth <= depth + DEPTH_W'(1);
      end else if (pop) begin
        wr_ptr <= rd_ptr;
        depth  <= depth - DEPTH_W'(1);
      end
      // A fresh error on the same edge as clear_err wins.
      overflow  <= (overflow  & ~clear_err) | ovf_set;
      underflow <= (underflow & ~clear_err) | unf_set;
    end
  end

  // NOTE: the stack array has no reset; its contents are meaningless until pushed, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_mem[wr_ptr] <= pc_plus1;
  end

`ifndef SYNTHESIS
  a_phase_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(phase_en));
  a_depth_bound:  assert property (@(posedge clk) disable iff (reset) depth <= DEPTH_MAX);
`endif

endmodule
